// File: rtl/rr_reg_arbiter_pkg.sv
// rtl/rr_reg_arbiter_pkg.sv - shared FSM encoding and pointer arithmetic for the register-bus arbiter
package rr_reg_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'b001,
    ST_BUSY = 3'b010,
    ST_DONE = 3'b100
  } arb_state_t;

  // (a + b) mod n for a < n, b < n
  function automatic int wrap_add(input int a, input int b, input int n);
    int s;
    s = a + b;
    return (s >= n) ? s - n : s;
  endfunction

endpackage

// File: rtl/rr_reg_arbiter_if.sv
// rtl/rr_reg_arbiter_if.sv - upstream APB-style requester bus and downstream register request bus
// Optional s_pslverr present when ARB_PSLVERR_EN is defined.
interface rr_reg_arbiter_if #(
  parameter int NUM_REQ    = 3,
  parameter int ADDR_WIDTH = 21,
  parameter int DATA_WIDTH = 16
);
  logic [NUM_REQ-1:0]            s_psel;
  logic [NUM_REQ-1:0]            s_penable;
  logic [NUM_REQ-1:0]            s_pwrite;
  logic [NUM_REQ*ADDR_WIDTH-1:0] s_paddr;
  logic [NUM_REQ*DATA_WIDTH-1:0] s_pwdata;
  logic [NUM_REQ-1:0]            s_pready;
  logic [DATA_WIDTH-1:0]         s_prdata;
`ifdef ARB_PSLVERR_EN
  logic [NUM_REQ-1:0]            s_pslverr;
`endif
  logic                          req_sel;
  logic                          req_write;
  logic [ADDR_WIDTH-1:0]         req_addr;
  logic [DATA_WIDTH-1:0]         req_wdata;
  logic                          req_ready;
  logic [DATA_WIDTH-1:0]         req_rdata;

  modport slave (
`ifdef ARB_PSLVERR_EN
    output s_pslverr,
`endif
    input  s_psel, s_penable, s_pwrite, s_paddr, s_pwdata,
    output s_pready, s_prdata,
    output req_sel, req_write, req_addr, req_wdata,
    input  req_ready, req_rdata
  );

  modport master (
`ifdef ARB_PSLVERR_EN
    input  s_pslverr,
`endif
    output s_psel, s_penable, s_pwrite, s_paddr, s_pwdata,
    input  s_pready, s_prdata,
    input  req_sel, req_write, req_addr, req_wdata,
    output req_ready, req_rdata
  );

endinterface

// File: rtl/rr_reg_arbiter_priority_sel.sv
// rtl/rr_reg_arbiter_priority_sel.sv - rotating-priority picker: first request at or after ptr, wrapping
module rr_priority_sel
  import rr_reg_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int IW      = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IW-1:0]      idx
);

  always_comb begin
    int   j;
    logic found;
    grant = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = wrap_add(int'(ptr), k, NUM_REQ);
      if (!found && req[j]) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        idx      = IW'(j);
      end
    end
  end

endmodule

// File: rtl/rr_reg_arbiter.sv
// rtl/rr_reg_arbiter.sv - round-robin arbiter sharing the register request bus among APB-style masters
// Define ARB_PSLVERR_EN to flag timed-out grants on s_pslverr.
module rr_reg_arbiter
  import rr_reg_arbiter_pkg::*;
#(
  parameter int NUM_REQ     = 3,
  parameter int ADDR_WIDTH  = 21,
  parameter int DATA_WIDTH  = 16,
  parameter int CFG_TIMEOUT = 16
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [CFG_TIMEOUT-1:0]     cfg_timeout,
  rr_reg_arbiter_if.slave            bus,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       timeout_evt
);

  localparam int IW = $clog2(NUM_REQ);

  arb_state_t             state_q, state_d;
  logic [IW-1:0]          ptr_q, ptr_d, grant_q, grant_d;
  logic [CFG_TIMEOUT-1:0] cnt_q, cnt_d, tmo_q, tmo_d;
  logic                   sel_q, sel_d, write_q, write_d, evt_q, evt_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [DATA_WIDTH-1:0]  wdata_q, wdata_d, prdata_q, prdata_d;
  logic [NUM_REQ-1:0]     pready_q, pready_d;
`ifdef ARB_PSLVERR_EN
  logic [NUM_REQ-1:0]     slverr_q, slverr_d;
`endif

  logic [NUM_REQ-1:0]     valid, pick_oh, done_oh;
  logic [IW-1:0]          pick_idx;
  logic [ADDR_WIDTH-1:0]  pick_addr;
  logic [DATA_WIDTH-1:0]  pick_wdata;
  logic                   pick_write;
  logic                   tmo_hit;

  // A requester still seeing its pready must not be re-granted
  assign valid   = bus.s_psel & bus.s_penable & ~pready_q;
  assign done_oh = NUM_REQ'(1) << grant_q;
  assign tmo_hit = (tmo_q != '0) && (cnt_q == tmo_q - CFG_TIMEOUT'(1));

  rr_priority_sel #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_sel (
    .req   (valid),
    .ptr   (ptr_q),
    .grant (pick_oh),
    .idx   (pick_idx)
  );

  always_comb begin
    pick_addr  = '0;
    pick_wdata = '0;
    pick_write = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_oh[i]) begin
        pick_addr  = pick_addr  | bus.s_paddr[i*ADDR_WIDTH +: ADDR_WIDTH];
        pick_wdata = pick_wdata | bus.s_pwdata[i*DATA_WIDTH +: DATA_WIDTH];
        pick_write = pick_write | bus.s_pwrite[i];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    grant_d  = grant_q;
    cnt_d    = cnt_q;
    tmo_d    = tmo_q;
    sel_d    = sel_q;
    write_d  = write_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    prdata_d = prdata_q;
    pready_d = '0;
    evt_d    = 1'b0;
`ifdef ARB_PSLVERR_EN
    slverr_d = '0;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (|pick_oh) begin
          grant_d = pick_idx;
          addr_d  = pick_addr;
          wdata_d = pick_wdata;
          write_d = pick_write;
          tmo_d   = cfg_timeout;
          cnt_d   = '0;
          sel_d   = 1'b1;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        cnt_d = cnt_q + CFG_TIMEOUT'(1);
        if (bus.req_ready) begin
          prdata_d = bus.req_rdata;
          pready_d = done_oh;
          sel_d    = 1'b0;
          state_d  = ST_DONE;
        end else if (tmo_hit) begin
          prdata_d = '0;
          pready_d = done_oh;
          evt_d    = 1'b1;
`ifdef ARB_PSLVERR_EN
          slverr_d = done_oh;
`endif
          sel_d    = 1'b0;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: begin
        ptr_d   = IW'(wrap_add(int'(grant_q), 1, NUM_REQ));
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= ST_IDLE;
      ptr_q    <= '0;
      grant_q  <= '0;
      cnt_q    <= '0;
      tmo_q    <= '0;
      sel_q    <= 1'b0;
      write_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      prdata_q <= '0;
      pready_q <= '0;
      evt_q    <= 1'b0;
`ifdef ARB_PSLVERR_EN
      slverr_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      grant_q  <= grant_d;
      cnt_q    <= cnt_d;
      tmo_q    <= tmo_d;
      sel_q    <= sel_d;
      write_q  <= write_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      prdata_q <= prdata_d;
      pready_q <= pready_d;
      evt_q    <= evt_d;
`ifdef ARB_PSLVERR_EN
      slverr_q <= slverr_d;
`endif
    end
  end

  assign bus.s_pready  = pready_q;
  assign bus.s_prdata  = prdata_q;
  assign bus.req_sel   = sel_q;
  assign bus.req_write = write_q;
  assign bus.req_addr  = addr_q;
  assign bus.req_wdata = wdata_q;
`ifdef ARB_PSLVERR_EN
  assign bus.s_pslverr = slverr_q;
`endif
  assign grant_id      = grant_q;
  assign timeout_evt   = evt_q;

endmodule

// File: tb/tb_rr_reg_arbiter.sv
// tb/tb_rr_reg_arbiter.sv - directed bench with a transaction-level reference model for rr_reg_arbiter
module tb_rr_reg_arbiter;

  localparam int N  = 3;
  localparam int AW = 21;
  localparam int DW = 16;
  localparam int TW = 16;
  localparam int P_IDLE = 0, P_BUSY = 1, P_DONE = 2;

  logic          clk = 1'b0;
  logic          rstn;
  logic [TW-1:0] cfg_timeout;
  logic [1:0]    grant_id;
  logic          timeout_evt;

  rr_reg_arbiter_if #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  rr_reg_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CFG_TIMEOUT(TW)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .cfg_timeout (cfg_timeout),
    .bus         (bus),
    .grant_id    (grant_id),
    .timeout_evt (timeout_evt)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one transaction at a time, fairness by distance from the pointer
  int            m_phase = P_IDLE, m_ptr = 0, m_owner = 0, m_busy = 0, m_tmo = 0, m_grant = 0;
  logic          m_sel = 1'b0, m_write = 1'b0, m_evt = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0, m_prdata = '0;
  logic [N-1:0]  m_pready = '0, m_slverr = '0;

  always @(posedge clk or negedge rstn) begin
    int best, pick, d;
    if (!rstn) begin
      m_phase = P_IDLE; m_ptr = 0; m_owner = 0; m_busy = 0; m_tmo = 0; m_grant = 0;
      m_sel = 0; m_write = 0; m_evt = 0; m_addr = '0; m_wdata = '0; m_prdata = '0;
      m_pready = '0; m_slverr = '0;
    end else begin
      case (m_phase)
        P_IDLE: begin
          best = N; pick = -1;
          for (int i = 0; i < N; i++) begin
            d = (i - m_ptr + N) % N;
            if (bus.s_psel[i] && bus.s_penable[i] && !m_pready[i] && d < best) begin
              best = d; pick = i;
            end
          end
          if (pick >= 0) begin
            m_owner = pick; m_grant = pick;
            m_addr  = bus.s_paddr[pick*AW +: AW];
            m_wdata = bus.s_pwdata[pick*DW +: DW];
            m_write = bus.s_pwrite[pick];
            m_tmo   = int'(cfg_timeout);
            m_busy  = 0; m_sel = 1; m_phase = P_BUSY;
          end
        end
        P_BUSY: begin
          m_busy++;
          if (bus.req_ready) begin
            m_prdata = bus.req_rdata; m_pready[m_owner] = 1'b1;
            m_sel = 0; m_phase = P_DONE;
          end else if (m_tmo != 0 && m_busy == m_tmo) begin
            m_prdata = '0; m_pready[m_owner] = 1'b1; m_evt = 1; m_slverr[m_owner] = 1'b1;
            m_sel = 0; m_phase = P_DONE;
          end
        end
        default: begin
          m_pready = '0; m_evt = 0; m_slverr = '0;
          m_ptr = (m_owner + 1) % N; m_phase = P_IDLE;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    check("req_sel", bus.req_sel, m_sel);
    check("s_pready", bus.s_pready, m_pready);
    check("s_prdata", bus.s_prdata, m_prdata);
    check("timeout_evt", timeout_evt, m_evt);
    check("grant_id", grant_id, m_grant);
`ifdef ARB_PSLVERR_EN
    check("s_pslverr", bus.s_pslverr, m_slverr);
`endif
    if (m_sel) begin
      check("req_addr", bus.req_addr, m_addr);
      check("req_write", bus.req_write, m_write);
      check("req_wdata", bus.req_wdata, m_wdata);
    end
  end

  // Downstream responder: ready on the (resp_delay+1)-th cycle of req_sel; -1 never answers
  int            resp_delay = -1;
  logic [DW-1:0] resp_data = '0;
  int            age = 0;
  always @(negedge clk) begin
    if (!rstn || !bus.req_sel) begin
      age = 0;
      bus.req_ready = 1'b0;
    end else begin
      age++;
      bus.req_ready = (resp_delay >= 0) && (age == resp_delay + 1);
    end
    bus.req_rdata = resp_data;
  end

  int sel_total = 0, evt_total = 0;
  always @(negedge clk) begin
    if (bus.req_sel) sel_total++;
    if (timeout_evt) evt_total++;
  end

  task automatic start_req(input int i, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.s_psel[i] = 1'b1;
    bus.s_penable[i] = 1'b1;
    bus.s_pwrite[i] = wr;
    bus.s_paddr[i*AW +: AW] = a;
    bus.s_pwdata[i*DW +: DW] = d;
  endtask

  task automatic stop_req(input int i);
    bus.s_psel[i] = 1'b0;
    bus.s_penable[i] = 1'b0;
  endtask

  task automatic wait_pready(input int i, input int limit, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.s_pready[i] && n < limit);
    if (!bus.s_pready[i]) begin
      vectors++; miscompares++;
      $display("FAIL pready_wait: requester %0d saw no pready within %0d cycles", i, limit);
    end
  endtask

  task automatic wait_any(input int limit, output int idx);
    int n;
    n = 0; idx = -1;
    do begin
      @(negedge clk);
      n++;
    end while (bus.s_pready == '0 && n < limit);
    for (int i = 0; i < N; i++) if (bus.s_pready[i]) idx = i;
    if (idx < 0) begin
      vectors++; miscompares++;
      $display("FAIL grant_wait: no pready within %0d cycles", limit);
    end
  endtask

  initial begin
    int n, idx, s0, e0;
    int exp_order[4];
    exp_order = '{0, 1, 2, 0};
    rstn = 1'b0;
    cfg_timeout = '0;
    bus.s_psel = '0; bus.s_penable = '0; bus.s_pwrite = '0;
    bus.s_paddr = '0; bus.s_pwdata = '0;
    repeat (3) @(negedge clk);
    check("rst_req_sel", bus.req_sel, 0);
    check("rst_pready", bus.s_pready, 0);
    check("rst_grant_id", grant_id, 0);
    check("rst_prdata", bus.s_prdata, 0);
    #2 rstn = 1'b1;

    // Single write from requester 1, ready two cycles after req_sel
    resp_delay = 2; resp_data = 16'h5A5A;
    @(negedge clk);
    start_req(1, 1'b1, 21'h00010, 16'hBEEF);
    @(negedge clk);
    check("single_sel", bus.req_sel, 1);
    check("single_write", bus.req_write, 1);
    check("single_addr", bus.req_addr, 32'h10);
    check("single_grant", grant_id, 1);
    wait_pready(1, 20, n);
    check("single_latency", n + 1, 4);
    check("single_pready", bus.s_pready, 3'b010);
    stop_req(1);

    // Contention from reset: all three held valid
    @(negedge clk);
    #2 rstn = 1'b0;
    @(negedge clk);
    resp_delay = 1; resp_data = 16'h0F0F;
    start_req(0, 1'b1, 21'h00100, 16'h1111);
    start_req(1, 1'b0, 21'h00200, 16'h0000);
    start_req(2, 1'b1, 21'h00300, 16'h3333);
    #2 rstn = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_any(20, idx);
      check("rr_order", idx, exp_order[k]);
    end
    stop_req(0); stop_req(1); stop_req(2);
    repeat (3) @(negedge clk);

    // Timeout after 4 BUSY cycles
    cfg_timeout = 16'd4; resp_delay = -1;
    s0 = sel_total; e0 = evt_total;
    start_req(2, 1'b0, 21'h1F0F0, 16'h0000);
    wait_pready(2, 50, n);
    check("tmo_latency", n, 5);
    check("tmo_evt", timeout_evt, 1);
    check("tmo_prdata", bus.s_prdata, 0);
    check("tmo_pready", bus.s_pready, 3'b100);
`ifdef ARB_PSLVERR_EN
    check("tmo_pslverr", bus.s_pslverr, 3'b100);
`endif
    stop_req(2);
    repeat (2) @(negedge clk);
    check("tmo_sel_cycles", sel_total - s0, 4);
    check("tmo_evt_count", evt_total - e0, 1);

    // Ready arrives on the very cycle the timeout would fire
    resp_delay = 3; resp_data = 16'hA5A5;
    e0 = evt_total;
    start_req(1, 1'b0, 21'h00ABC, 16'h0000);
    wait_pready(1, 50, n);
    check("race_latency", n, 5);
    check("race_prdata", bus.s_prdata, 16'hA5A5);
    check("race_evt", timeout_evt, 0);
    stop_req(1);
    repeat (2) @(negedge clk);
    check("race_evt_count", evt_total - e0, 0);

    // Timeout disabled, slow target
    cfg_timeout = '0; resp_delay = 999; resp_data = 16'h1234;
    e0 = evt_total;
    start_req(0, 1'b0, 21'h00042, 16'h0000);
    wait_pready(0, 1200, n);
    check("slow_latency", n, 1001);
    check("slow_prdata", bus.s_prdata, 16'h1234);
    stop_req(0);
    repeat (2) @(negedge clk);
    check("slow_evt_count", evt_total - e0, 0);

    // Reset while BUSY, then pointer must be back at requester 0
    resp_delay = -1;
    start_req(1, 1'b1, 21'h00077, 16'h7777);
    repeat (3) @(negedge clk);
    check("rst_mid_sel_before", bus.req_sel, 1);
    #2 rstn = 1'b0;
    #1;
    check("rst_mid_sel", bus.req_sel, 0);
    check("rst_mid_pready", bus.s_pready, 0);
    check("rst_mid_grant", grant_id, 0);
    stop_req(1);
    @(negedge clk);
    #2 rstn = 1'b1;
    @(negedge clk);
    resp_delay = 1; resp_data = 16'hC0DE;
    start_req(0, 1'b0, 21'h00001, 16'h0000);
    start_req(2, 1'b0, 21'h00002, 16'h0000);
    wait_pready(0, 20, n);
    check("post_rst_first", n, 3);
    check("post_rst_pready", bus.s_pready, 3'b001);
    stop_req(0);
    wait_pready(2, 20, n);
    check("post_rst_second", bus.s_pready, 3'b100);
    stop_req(2);
    repeat (5) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
